// File: rtl/ctrl_pipe_regs_if.sv
`default_nettype none
// ============================================================================
//  ctrl_pipe_regs_if
//  Decoder-to-datapath control bundle carried by ctrl_pipe_regs.
//  Revision: 1.0
// ============================================================================
interface ctrl_pipe_regs_if #(
    parameter int REG_BITS = 5
);
    logic                id_RegDst, id_ALUSrc1, id_ALUSrc2, id_MemToReg;
    logic                id_RegWrite, id_MemRead, id_MemWrite, id_Branch;
    logic                id_Jump, id_SignExtend, id_Jal, id_Jr;
    logic [3:0]          id_ALUOp;
    logic [REG_BITS-1:0] id_rs, id_rt, id_rd;
    logic                ex_Zero;

    logic                ex_ALUSrc1, ex_ALUSrc2, ex_SignExtend, ex_Jal, ex_Branch;
    logic [3:0]          ex_ALUOp;
    logic [REG_BITS-1:0] ex_WriteReg, mem_WriteReg, wb_WriteReg;
    logic                mem_MemRead, mem_MemWrite;
    logic                wb_MemToReg, wb_RegWrite, wb_Jal;
    logic                ex_RegWrite, mem_RegWrite;
    logic                PCWrite, IFIDWrite, IFFlush, BranchTaken;

    modport slave (
        input  id_RegDst, id_ALUSrc1, id_ALUSrc2, id_MemToReg, id_RegWrite,
               id_MemRead, id_MemWrite, id_Branch, id_Jump, id_SignExtend,
               id_Jal, id_Jr, id_ALUOp, id_rs, id_rt, id_rd, ex_Zero,
        output ex_ALUSrc1, ex_ALUSrc2, ex_SignExtend, ex_Jal, ex_Branch, ex_ALUOp,
               ex_WriteReg, mem_WriteReg, wb_WriteReg, mem_MemRead, mem_MemWrite,
               wb_MemToReg, wb_RegWrite, wb_Jal, ex_RegWrite, mem_RegWrite,
               PCWrite, IFIDWrite, IFFlush, BranchTaken
    );

    modport master (
        output id_RegDst, id_ALUSrc1, id_ALUSrc2, id_MemToReg, id_RegWrite,
               id_MemRead, id_MemWrite, id_Branch, id_Jump, id_SignExtend,
               id_Jal, id_Jr, id_ALUOp, id_rs, id_rt, id_rd, ex_Zero,
        input  ex_ALUSrc1, ex_ALUSrc2, ex_SignExtend, ex_Jal, ex_Branch, ex_ALUOp,
               ex_WriteReg, mem_WriteReg, wb_WriteReg, mem_MemRead, mem_MemWrite,
               wb_MemToReg, wb_RegWrite, wb_Jal, ex_RegWrite, mem_RegWrite,
               PCWrite, IFIDWrite, IFFlush, BranchTaken
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe_regs.sv
`default_nettype none
// ============================================================================
//  ctrl_pipe_regs
//  ID/EX, EX/MEM, MEM/WB control registers with stall, bubble and squash.
//  Optional macro CTRL_PIPE_HAZARD_EN enables load-use / Jr stall detection.
//  Revision: 1.0
// ============================================================================
module ctrl_pipe_regs #(
    parameter int REG_BITS = 5,
    parameter int LINK_REG = 31
) (
    input  wire                   CLK,
    input  wire                   Reset_L,
    ctrl_pipe_regs_if.slave       bus
);
    localparam logic [REG_BITS-1:0] C_LINK = LINK_REG[REG_BITS-1:0];

    typedef struct packed {
        logic                alu_src1, alu_src2, sign_extend, jal, branch;
        logic [3:0]          alu_op;
        logic [REG_BITS-1:0] write_reg;
        logic                mem_to_reg, reg_write, mem_read, mem_write;
    } idex_t;

    typedef struct packed {
        logic [REG_BITS-1:0] write_reg;
        logic                mem_to_reg, reg_write, mem_read, mem_write, jal;
    } exmem_t;

    typedef struct packed {
        logic [REG_BITS-1:0] write_reg;
        logic                mem_to_reg, reg_write, jal;
    } memwb_t;

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;

    logic branch_taken;
    logic hazard;
    logic stall;

`ifdef CTRL_PIPE_HAZARD_EN
    logic load_use;
    logic jr_hazard;

    always_comb begin
        load_use  = idex_q.mem_read && (idex_q.write_reg != '0) &&
                    ((idex_q.write_reg == bus.id_rs) || (idex_q.write_reg == bus.id_rt));
        jr_hazard = bus.id_Jr && (bus.id_rs != '0) &&
                    ((idex_q.reg_write && (idex_q.write_reg == bus.id_rs)) ||
                     (exmem_q.mem_read && (exmem_q.write_reg == bus.id_rs)));
        hazard    = load_use || jr_hazard;
    end
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{bus.id_Jr, bus.id_rs};
    assign hazard = 1'b0;
`endif

    always_comb begin
        branch_taken = idex_q.branch && bus.ex_Zero;
        // A taken branch squashes the ID instruction, so its stall is moot.
        stall        = hazard && !branch_taken;

        idex_d = '0;
        if (!(branch_taken || stall)) begin
            idex_d.alu_src1    = bus.id_ALUSrc1;
            idex_d.alu_src2    = bus.id_ALUSrc2;
            idex_d.sign_extend = bus.id_SignExtend;
            idex_d.jal         = bus.id_Jal;
            idex_d.branch      = bus.id_Branch;
            idex_d.alu_op      = bus.id_ALUOp;
            idex_d.write_reg   = bus.id_Jal ? C_LINK : (bus.id_RegDst ? bus.id_rd : bus.id_rt);
            idex_d.mem_to_reg  = bus.id_MemToReg;
            idex_d.reg_write   = bus.id_RegWrite;
            idex_d.mem_read    = bus.id_MemRead;
            idex_d.mem_write   = bus.id_MemWrite;
        end

        exmem_d.write_reg  = idex_q.write_reg;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.jal        = idex_q.jal;

        memwb_d.write_reg  = exmem_q.write_reg;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.jal        = exmem_q.jal;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.ex_ALUSrc1    = idex_q.alu_src1;
    assign bus.ex_ALUSrc2    = idex_q.alu_src2;
    assign bus.ex_SignExtend = idex_q.sign_extend;
    assign bus.ex_Jal        = idex_q.jal;
    assign bus.ex_Branch     = idex_q.branch;
    assign bus.ex_ALUOp      = idex_q.alu_op;
    assign bus.ex_WriteReg   = idex_q.write_reg;
    assign bus.ex_RegWrite   = idex_q.reg_write;

    assign bus.mem_WriteReg  = exmem_q.write_reg;
    assign bus.mem_MemRead   = exmem_q.mem_read;
    assign bus.mem_MemWrite  = exmem_q.mem_write;
    assign bus.mem_RegWrite  = exmem_q.reg_write;

    assign bus.wb_WriteReg   = memwb_q.write_reg;
    assign bus.wb_MemToReg   = memwb_q.mem_to_reg;
    assign bus.wb_RegWrite   = memwb_q.reg_write;
    assign bus.wb_Jal        = memwb_q.jal;

    assign bus.BranchTaken   = branch_taken;
    assign bus.PCWrite       = !stall;
    assign bus.IFIDWrite     = !stall;
    assign bus.IFFlush       = branch_taken || (bus.id_Jump && !stall);
endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_regs.sv
`default_nettype none
// ============================================================================
//  tb_ctrl_pipe_regs
//  Directed scenarios plus random control words against an instruction-level
//  pipeline model.
//  Revision: 1.0
// ============================================================================
module tb_ctrl_pipe_regs;
`ifdef CTRL_PIPE_HAZARD_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    typedef struct packed {
        bit regdst, alusrc1, alusrc2, memtoreg, regwrite, memread, memwrite;
        bit branch, jump, signext, jal, jr;
        bit [3:0] aluop;
        bit [4:0] rs, rt, rd;
    } id_t;

    // One in-flight instruction as seen by the later stages.
    typedef struct packed {
        bit alusrc1, alusrc2, signext, jal, branch;
        bit [3:0] aluop;
        bit [4:0] wreg;
        bit memtoreg, regwrite, memread, memwrite;
    } ctl_t;

    logic CLK;
    logic Reset_L;
    int   errors = 0;
    int   checks = 0;

    ctl_t ex_m, mem_m, wb_m;
    bit   last_stall;

    ctrl_pipe_regs_if #(.REG_BITS(5)) pif ();

    ctrl_pipe_regs #(.REG_BITS(5), .LINK_REG(31)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (pif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic id_t nop();
        return '0;
    endfunction

    function automatic id_t lw(input bit [4:0] rt, input bit [4:0] rs);
        id_t x = '0;
        x.regwrite = 1; x.memread = 1; x.memtoreg = 1; x.alusrc2 = 1;
        x.signext = 1; x.aluop = 4'd2; x.rt = rt; x.rs = rs;
        return x;
    endfunction

    function automatic id_t add(input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
        id_t x = '0;
        x.regdst = 1; x.regwrite = 1; x.aluop = 4'd1; x.rd = rd; x.rs = rs; x.rt = rt;
        return x;
    endfunction

    function automatic id_t jal();
        id_t x = '0;
        x.jump = 1; x.jal = 1; x.regwrite = 1; x.alusrc1 = 1;
        return x;
    endfunction

    function automatic id_t jr(input bit [4:0] rs);
        id_t x = '0;
        x.jump = 1; x.jr = 1; x.rs = rs;
        return x;
    endfunction

    function automatic id_t rnd_id();
        id_t x;
        x = id_t'({$urandom, $urandom});
        x.rs = 5'($urandom_range(0, 3));
        x.rt = 5'($urandom_range(0, 3));
        x.rd = 5'($urandom_range(0, 3));
        x.jal = ($urandom_range(0, 7) == 0);
        x.jr  = ($urandom_range(0, 5) == 0);
        x.jump = x.jal | x.jr | ($urandom_range(0, 9) == 0);
        x.branch = ($urandom_range(0, 3) == 0);
        return x;
    endfunction

    function automatic ctl_t enter_ex(input id_t x);
        ctl_t c;
        c.alusrc1 = x.alusrc1; c.alusrc2 = x.alusrc2; c.signext = x.signext;
        c.jal = x.jal; c.branch = x.branch; c.aluop = x.aluop;
        c.wreg = x.jal ? 5'd31 : (x.regdst ? x.rd : x.rt);
        c.memtoreg = x.memtoreg; c.regwrite = x.regwrite;
        c.memread = x.memread; c.memwrite = x.memwrite;
        return c;
    endfunction

    task automatic drive(input id_t x, input bit zero);
        pif.id_RegDst = x.regdst;   pif.id_ALUSrc1 = x.alusrc1; pif.id_ALUSrc2 = x.alusrc2;
        pif.id_MemToReg = x.memtoreg; pif.id_RegWrite = x.regwrite; pif.id_MemRead = x.memread;
        pif.id_MemWrite = x.memwrite; pif.id_Branch = x.branch; pif.id_Jump = x.jump;
        pif.id_SignExtend = x.signext; pif.id_Jal = x.jal; pif.id_Jr = x.jr;
        pif.id_ALUOp = x.aluop; pif.id_rs = x.rs; pif.id_rt = x.rt; pif.id_rd = x.rd;
        pif.ex_Zero = zero;
    endtask

    // Present x in ID for one cycle, check all outputs, then advance the model.
    task automatic cycle(input id_t x, input bit zero);
        bit bt, lu, jh, stall, flush;
        ctl_t nx;
        drive(x, zero);
        #2;
        bt = ex_m.branch && zero;
        lu = ex_m.memread && ex_m.wreg != 0 && (ex_m.wreg == x.rs || ex_m.wreg == x.rt);
        jh = x.jr && x.rs != 0 &&
             ((ex_m.regwrite && ex_m.wreg == x.rs) || (mem_m.memread && mem_m.wreg == x.rs));
        stall = HAZ && (lu || jh) && !bt;
        flush = bt || (x.jump && !stall);
        chk("ctrl", {pif.PCWrite, pif.IFIDWrite, pif.IFFlush, pif.BranchTaken},
                    {!stall, !stall, flush, bt});
        chk("ex", {pif.ex_ALUSrc1, pif.ex_ALUSrc2, pif.ex_SignExtend, pif.ex_Jal,
                   pif.ex_Branch, pif.ex_ALUOp, pif.ex_WriteReg, pif.ex_RegWrite},
                  {ex_m.alusrc1, ex_m.alusrc2, ex_m.signext, ex_m.jal,
                   ex_m.branch, ex_m.aluop, ex_m.wreg, ex_m.regwrite});
        chk("mem", {pif.mem_MemRead, pif.mem_MemWrite, pif.mem_WriteReg, pif.mem_RegWrite},
                   {mem_m.memread, mem_m.memwrite, mem_m.wreg, mem_m.regwrite});
        chk("wb", {pif.wb_MemToReg, pif.wb_RegWrite, pif.wb_Jal, pif.wb_WriteReg},
                  {wb_m.memtoreg, wb_m.regwrite, wb_m.jal, wb_m.wreg});
        nx = (bt || stall) ? ctl_t'(0) : enter_ex(x);
        @(posedge CLK);
        #1;
        wb_m = mem_m; mem_m = ex_m; ex_m = nx;
        last_stall = stall;
    endtask

    // Hold an instruction in ID until it is accepted.
    task automatic issue(input id_t x, input bit zero);
        int n = 0;
        do begin
            cycle(x, zero);
            n++;
        end while (last_stall && n < 4);
        if (last_stall) begin
            checks++;
            errors++;
            $error("FAIL stall_bound: observed=stall after %0d cycles expected=release", n);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ctrl"}, {pif.PCWrite, pif.IFIDWrite, pif.IFFlush, pif.BranchTaken}, 4'b1100);
        chk({tag, "_exop"}, 32'(pif.ex_ALUOp), 32'd0);
        chk({tag, "_wbrw"}, 32'(pif.wb_RegWrite), 32'd0);
        chk({tag, "_regs"}, {pif.ex_WriteReg, pif.mem_WriteReg, pif.wb_WriteReg,
                             pif.ex_RegWrite, pif.mem_RegWrite, pif.mem_MemRead,
                             pif.wb_Jal, pif.ex_Branch}, 32'd0);
    endtask

    initial begin
        id_t br;
        Reset_L = 1'b0;
        ex_m = '0; mem_m = '0; wb_m = '0;
        last_stall = 0;
        drive(nop(), 1'b0);
        #3;
        chk_reset_values("reset");
        #5;
        Reset_L = 1'b1;
        @(posedge CLK);
        #1;

        // Load-use: lw r8 then add using r8.
        issue(lw(5'd8, 5'd1), 1'b0);
        issue(add(5'd9, 5'd8, 5'd2), 1'b0);
        repeat (4) cycle(nop(), 1'b0);

        // Jal: link register and flush.
        issue(jal(), 1'b0);
        repeat (4) cycle(nop(), 1'b0);

        // Taken branch in EX that also carries a load-use match against ID.
        br = lw(5'd9, 5'd0);
        br.branch = 1;
        issue(br, 1'b0);
        issue(add(5'd10, 5'd9, 5'd9), 1'b1);
        repeat (3) cycle(nop(), 1'b0);

        // Jr behind a load of r31.
        issue(lw(5'd31, 5'd4), 1'b0);
        issue(jr(5'd31), 1'b0);
        repeat (3) cycle(nop(), 1'b0);

        // Write to r0 passes through; r0 never causes a stall.
        issue(lw(5'd0, 5'd3), 1'b0);
        issue(add(5'd0, 5'd0, 5'd0), 1'b0);
        repeat (3) cycle(nop(), 1'b0);

        // Asynchronous reset between edges with a full pipeline.
        issue(lw(5'd5, 5'd1), 1'b0);
        issue(add(5'd6, 5'd2, 5'd3), 1'b0);
        issue(jal(), 1'b0);
        drive(nop(), 1'b0);
        #2;
        Reset_L = 1'b0;
        #1;
        chk_reset_values("midreset");
        ex_m = '0; mem_m = '0; wb_m = '0;
        @(posedge CLK);
        #1;
        Reset_L = 1'b1;

        for (int i = 0; i < 400; i++) begin
            cycle(rnd_id(), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
